conv3x3_mac: RTL

CONV3X3_MAC -- requirements
Module: conv3x3_mac

---
 rtl/conv3x3_mac_pkg.sv | 13 +
 rtl/conv3x3_mac_dot9.sv | 78 +++++++
 rtl/conv3x3_mac.sv | 82 ++++++++
 3 files changed

// File: rtl/conv3x3_mac_pkg.sv
// Shared widths and tap count for the 3x3 convolution MAC datapath.
// Products are exact 8x8 signed multiplies; nine of them always fit in SUM_W bits.
package conv3x3_mac_pkg;
  localparam int DATA_W = 8;
  localparam int PROD_W = 16;
  localparam int SUM_W  = 20;
  localparam int TAPS   = 9;

  function automatic logic signed [PROD_W-1:0] mul8(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return PROD_W'(a) * PROD_W'(b);
  endfunction
endpackage

// File: rtl/conv3x3_mac_dot9.sv
// Two-stage 9-tap signed dot product: stage 1 registers products, stage 2 their sum.
// Both stages advance only when en is high; flags travel alongside so bubbles stay bubbles.
module conv_dot9
  import conv3x3_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] pix0,
  input  logic signed [DATA_W-1:0] pix1,
  input  logic signed [DATA_W-1:0] pix2,
  input  logic signed [DATA_W-1:0] pix3,
  input  logic signed [DATA_W-1:0] pix4,
  input  logic signed [DATA_W-1:0] pix5,
  input  logic signed [DATA_W-1:0] pix6,
  input  logic signed [DATA_W-1:0] pix7,
  input  logic signed [DATA_W-1:0] pix8,
  input  logic signed [DATA_W-1:0] kernel0,
  input  logic signed [DATA_W-1:0] kernel1,
  input  logic signed [DATA_W-1:0] kernel2,
  input  logic signed [DATA_W-1:0] kernel3,
  input  logic signed [DATA_W-1:0] kernel4,
  input  logic signed [DATA_W-1:0] kernel5,
  input  logic signed [DATA_W-1:0] kernel6,
  input  logic signed [DATA_W-1:0] kernel7,
  input  logic signed [DATA_W-1:0] kernel8,
  output logic                     sum_valid,
  output logic                     sum_first,
  output logic                     sum_last,
  output logic signed [SUM_W-1:0]  sum
);
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic signed [SUM_W-1:0]  prod_sum;
  logic                     s1_valid, s1_first, s1_last;

  always_comb begin
    prod_d[0] = mul8(pix0, kernel0);
    prod_d[1] = mul8(pix1, kernel1);
    prod_d[2] = mul8(pix2, kernel2);
    prod_d[3] = mul8(pix3, kernel3);
    prod_d[4] = mul8(pix4, kernel4);
    prod_d[5] = mul8(pix5, kernel5);
    prod_d[6] = mul8(pix6, kernel6);
    prod_d[7] = mul8(pix7, kernel7);
    prod_d[8] = mul8(pix8, kernel8);
  end

  always_comb begin
    prod_sum = '0;
    for (int i = 0; i < TAPS; i++) prod_sum = prod_sum + SUM_W'(prod_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) prod_q[i] <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      sum       <= '0;
      sum_valid <= 1'b0;
      sum_first <= 1'b0;
      sum_last  <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < TAPS; i++) prod_q[i] <= prod_d[i];
      s1_valid  <= in_valid;
      s1_first  <= in_first;
      s1_last   <= in_last;
      sum       <= prod_sum;
      sum_valid <= s1_valid;
      sum_first <= s1_first;
      sum_last  <= s1_last;
    end
  end
endmodule

// File: rtl/conv3x3_mac.sv
// 3x3 conv MAC: dot9 pipeline plus channel accumulator, 3 register stages, whole pipe stalls
// while a result waits on out_ready. Define CONV_RELU_EN to clamp published results at 0.
module conv3x3_mac
  import conv3x3_mac_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic signed [DATA_W-1:0] pix0,
  input  logic signed [DATA_W-1:0] pix1,
  input  logic signed [DATA_W-1:0] pix2,
  input  logic signed [DATA_W-1:0] pix3,
  input  logic signed [DATA_W-1:0] pix4,
  input  logic signed [DATA_W-1:0] pix5,
  input  logic signed [DATA_W-1:0] pix6,
  input  logic signed [DATA_W-1:0] pix7,
  input  logic signed [DATA_W-1:0] pix8,
  input  logic signed [DATA_W-1:0] kernel0,
  input  logic signed [DATA_W-1:0] kernel1,
  input  logic signed [DATA_W-1:0] kernel2,
  input  logic signed [DATA_W-1:0] kernel3,
  input  logic signed [DATA_W-1:0] kernel4,
  input  logic signed [DATA_W-1:0] kernel5,
  input  logic signed [DATA_W-1:0] kernel6,
  input  logic signed [DATA_W-1:0] kernel7,
  input  logic signed [DATA_W-1:0] kernel8,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data
);
  logic                    en;
  logic                    s2_valid, s2_first, s2_last;
  logic signed [SUM_W-1:0] s2_sum;
  logic signed [ACC_W-1:0] acc, acc_next, sum_ext, result;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  conv_dot9 u_dot9 (
    .clk(clk), .rst(rst), .en(en),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .pix0(pix0), .pix1(pix1), .pix2(pix2), .pix3(pix3), .pix4(pix4),
    .pix5(pix5), .pix6(pix6), .pix7(pix7), .pix8(pix8),
    .kernel0(kernel0), .kernel1(kernel1), .kernel2(kernel2), .kernel3(kernel3),
    .kernel4(kernel4), .kernel5(kernel5), .kernel6(kernel6), .kernel7(kernel7),
    .kernel8(kernel8),
    .sum_valid(s2_valid), .sum_first(s2_first), .sum_last(s2_last), .sum(s2_sum)
  );

  assign sum_ext  = ACC_W'(s2_sum);
  assign acc_next = s2_first ? sum_ext : acc + sum_ext;

`ifdef CONV_RELU_EN
  assign result = acc_next[ACC_W-1] ? '0 : acc_next;
`else
  assign result = acc_next;
`endif

  // When enabled with out_valid high, out_ready must be high, so the old result is consumed here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          acc      <= '0;
          out_data <= result;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end
endmodule
